// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-END_COUNT up/down counter with synchronous clear and load,
// wrap or saturate at the limits, a cascade carry and registered status pulses.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous, active-low reset
//   enable_i     count enable (cascade input)
//   up_down_i    direction, 1 = up, 0 = down
//   clear_i      synchronous clear to 0
//   load_i       synchronous load of load_val_i
//   load_val_i   value to load; out-of-range values load END_COUNT-1
//   count_o      current count (registered)
//   tc_o         terminal count for the current direction (combinational)
//   carry_out_o  tc_o & enable_i, drives the next stage's enable_i
//   wrap_o       one-cycle pulse after a wrap
//   sat_o        high while held at a limit (SATURATE = 1 only)
//   load_err_o   one-cycle pulse after an out-of-range load
module mod_updown_counter #(
   parameter int unsigned END_COUNT = 10,
   parameter bit          SATURATE  = 1'b0,
   localparam int unsigned W = (END_COUNT > 2) ? $clog2(END_COUNT) : 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable_i,
   input  logic         up_down_i,
   input  logic         clear_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic [W-1:0] count_o,
   output logic         tc_o,
   output logic         carry_out_o,
   output logic         wrap_o,
   output logic         sat_o,
   output logic         load_err_o
);

   localparam logic [W-1:0] MaxVal = W'(END_COUNT - 1);
   localparam logic [W-1:0] Zero   = '0;
   localparam logic [W-1:0] One    = W'(1);

   logic [W-1:0] count_q, count_d;
   logic         wrap_q, wrap_d;
   logic         sat_q, sat_d;
   logic         load_err_q, load_err_d;

   always_comb begin
      count_d    = count_q;
      wrap_d     = 1'b0;
      sat_d      = sat_q;
      load_err_d = 1'b0;
      if (clear_i) begin
         count_d = Zero;
         sat_d   = 1'b0;
      end else if (load_i) begin
         sat_d = 1'b0;
         if (load_val_i > MaxVal) begin
            count_d    = MaxVal;
            load_err_d = 1'b1;
         end else begin
            count_d = load_val_i;
         end
      end else if (enable_i) begin
         if (up_down_i) begin
            if (count_q == MaxVal) begin
               if (SATURATE) begin
                  sat_d = 1'b1;
               end else begin
                  count_d = Zero;
                  wrap_d  = 1'b1;
               end
            end else begin
               count_d = count_q + One;
               sat_d   = 1'b0;
            end
         end else begin
            if (count_q == Zero) begin
               if (SATURATE) begin
                  sat_d = 1'b1;
               end else begin
                  count_d = MaxVal;
                  wrap_d  = 1'b1;
               end
            end else begin
               count_d = count_q - One;
               sat_d   = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q    <= Zero;
         wrap_q     <= 1'b0;
         sat_q      <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         wrap_q     <= wrap_d;
         sat_q      <= sat_d;
         load_err_q <= load_err_d;
      end
   end

   // Terminal count follows the live direction so a turnaround at a limit is seen at once.
   always_comb begin
      tc_o        = up_down_i ? (count_q == MaxVal) : (count_q == Zero);
      carry_out_o = tc_o & enable_i;
   end

   assign count_o    = count_q;
   assign wrap_o     = wrap_q;
   assign sat_o      = sat_q;
   assign load_err_o = load_err_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Randomised bench for mod_updown_counter: four stand-alone instances (mod 10 wrap, mod 10
// saturate, mod 2, mod 16) share one stimulus stream, plus a two-digit mod-10 chain.
module tb_mod_updown_counter;

   localparam int N = 6;
   localparam int EC [N]  = '{10, 10, 2, 16, 10, 10};
   localparam int WD [N]  = '{4, 4, 1, 4, 4, 4};
   localparam bit SAT [N] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0, up = 1'b1, clr = 1'b0, ld = 1'b0, ch_en = 1'b0;
   logic [4:0] lv = '0;

   logic [3:0] cnt_a, cnt_b, cnt_16, cnt_lo, cnt_hi;
   logic [0:0] cnt_2;
   logic       tc_v [N];
   logic       cy_v [N];
   logic       wr_v [N];
   logic       st_v [N];
   logic       le_v [N];
   logic       lo_carry;

   int m_cnt [N];
   int m_wrap [N];
   int m_sat [N];
   int m_lerr [N];

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mod_updown_counter #(.END_COUNT(10), .SATURATE(1'b0)) u_a (
      .clk(clk), .reset(rst_n), .enable_i(en), .up_down_i(up), .clear_i(clr), .load_i(ld),
      .load_val_i(lv[3:0]), .count_o(cnt_a), .tc_o(tc_v[0]), .carry_out_o(cy_v[0]),
      .wrap_o(wr_v[0]), .sat_o(st_v[0]), .load_err_o(le_v[0]));

   mod_updown_counter #(.END_COUNT(10), .SATURATE(1'b1)) u_b (
      .clk(clk), .reset(rst_n), .enable_i(en), .up_down_i(up), .clear_i(clr), .load_i(ld),
      .load_val_i(lv[3:0]), .count_o(cnt_b), .tc_o(tc_v[1]), .carry_out_o(cy_v[1]),
      .wrap_o(wr_v[1]), .sat_o(st_v[1]), .load_err_o(le_v[1]));

   mod_updown_counter #(.END_COUNT(2), .SATURATE(1'b0)) u_2 (
      .clk(clk), .reset(rst_n), .enable_i(en), .up_down_i(up), .clear_i(clr), .load_i(ld),
      .load_val_i(lv[0:0]), .count_o(cnt_2), .tc_o(tc_v[2]), .carry_out_o(cy_v[2]),
      .wrap_o(wr_v[2]), .sat_o(st_v[2]), .load_err_o(le_v[2]));

   mod_updown_counter #(.END_COUNT(16), .SATURATE(1'b0)) u_16 (
      .clk(clk), .reset(rst_n), .enable_i(en), .up_down_i(up), .clear_i(clr), .load_i(ld),
      .load_val_i(lv[3:0]), .count_o(cnt_16), .tc_o(tc_v[3]), .carry_out_o(cy_v[3]),
      .wrap_o(wr_v[3]), .sat_o(st_v[3]), .load_err_o(le_v[3]));

   mod_updown_counter #(.END_COUNT(10), .SATURATE(1'b0)) u_lo (
      .clk(clk), .reset(rst_n), .enable_i(ch_en), .up_down_i(up), .clear_i(1'b0),
      .load_i(1'b0), .load_val_i(4'd0), .count_o(cnt_lo), .tc_o(tc_v[4]),
      .carry_out_o(cy_v[4]), .wrap_o(wr_v[4]), .sat_o(st_v[4]), .load_err_o(le_v[4]));

   assign lo_carry = cy_v[4];

   mod_updown_counter #(.END_COUNT(10), .SATURATE(1'b0)) u_hi (
      .clk(clk), .reset(rst_n), .enable_i(lo_carry), .up_down_i(up), .clear_i(1'b0),
      .load_i(1'b0), .load_val_i(4'd0), .count_o(cnt_hi), .tc_o(tc_v[5]),
      .carry_out_o(cy_v[5]), .wrap_o(wr_v[5]), .sat_o(st_v[5]), .load_err_o(le_v[5]));

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the counter's value range.
   task automatic model_step(input int i, input bit r, input bit c, input bit l, input int lvv,
                             input bit e, input bit u);
      int ec  = EC[i];
      int lve = lvv % (1 << WD[i]);
      int nxt;
      if (!r || c) begin
         m_cnt[i] = 0; m_wrap[i] = 0; m_sat[i] = 0; m_lerr[i] = 0;
      end else if (l) begin
         m_wrap[i] = 0; m_sat[i] = 0;
         m_lerr[i] = (lve >= ec) ? 1 : 0;
         m_cnt[i]  = (lve >= ec) ? ec - 1 : lve;
      end else begin
         m_lerr[i] = 0;
         m_wrap[i] = 0;
         if (e) begin
            nxt = m_cnt[i] + (u ? 1 : -1);
            if (nxt >= 0 && nxt < ec) begin
               m_cnt[i] = nxt; m_sat[i] = 0;
            end else if (SAT[i]) begin
               m_sat[i] = 1;
            end else begin
               m_cnt[i] = (nxt + ec) % ec; m_wrap[i] = 1;
            end
         end
      end
   endtask

   function automatic bit model_tc(input int i, input bit u);
      return u ? (m_cnt[i] == EC[i] - 1) : (m_cnt[i] == 0);
   endfunction

   task automatic check_all();
      int  obs [N];
      bit  ein [N];
      obs[0] = int'(cnt_a); obs[1] = int'(cnt_b); obs[2] = int'(cnt_2);
      obs[3] = int'(cnt_16); obs[4] = int'(cnt_lo); obs[5] = int'(cnt_hi);
      for (int i = 0; i < 4; i++) ein[i] = en;
      ein[4] = ch_en;
      ein[5] = model_tc(4, up) & ch_en;
      for (int i = 0; i < N; i++) begin
         check_eq($sformatf("count[%0d]", i), obs[i], m_cnt[i]);
         check_eq($sformatf("range[%0d]", i), int'(obs[i] < EC[i]), 1);
         check_eq($sformatf("tc[%0d]", i), int'(tc_v[i]), int'(model_tc(i, up)));
         check_eq($sformatf("carry[%0d]", i), int'(cy_v[i]), int'(model_tc(i, up) & ein[i]));
         check_eq($sformatf("wrap[%0d]", i), int'(wr_v[i]), m_wrap[i]);
         check_eq($sformatf("sat[%0d]", i), int'(st_v[i]), m_sat[i]);
         check_eq($sformatf("load_err[%0d]", i), int'(le_v[i]), m_lerr[i]);
      end
   endtask

   // One clock: the model consumes the inputs present at this edge, then new inputs go on.
   task automatic apply(input bit r, input bit c, input bit l, input int v, input bit e,
                        input bit u, input bit ce);
      bit hi_en;
      @(posedge clk);
      #1;
      hi_en = model_tc(4, up) & ch_en;
      for (int i = 0; i < 4; i++) model_step(i, rst_n, clr, ld, int'(lv), en, up);
      model_step(4, rst_n, 1'b0, 1'b0, 0, ch_en, up);
      model_step(5, rst_n, 1'b0, 1'b0, 0, hi_en, up);
      rst_n = r; clr = c; ld = l; lv = 5'(v); en = e; up = u; ch_en = ce;
      #1;
      check_all();
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         m_cnt[i] = 0; m_wrap[i] = 0; m_sat[i] = 0; m_lerr[i] = 0;
      end
      // Reset, then count up 25 edges with the chain enabled.
      apply(0, 0, 0, 0, 0, 1, 0);
      apply(0, 0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 26; k++) apply(1, 0, 0, 0, 1, 1, 1);
      check_eq("chain_hi_after_25", int'(cnt_hi), 2);
      check_eq("chain_lo_after_25", int'(cnt_lo), 5);
      // Down from 0 after reset.
      apply(0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 20; k++) apply(1, 0, 0, 0, 1, 0, 1);
      // Saturation run from 7, then turn around.
      apply(1, 0, 1, 7, 0, 1, 0);
      for (int k = 0; k < 5; k++) apply(1, 0, 0, 0, 1, 1, 0);
      apply(1, 0, 0, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 1, 0, 0);
      apply(1, 0, 0, 0, 0, 0, 0);
      // Out-of-range load, clear beating load, reset beating load.
      apply(1, 0, 1, 12, 1, 1, 0);
      apply(1, 0, 0, 0, 0, 1, 0);
      apply(1, 1, 1, 4, 1, 1, 0);
      apply(1, 0, 0, 0, 0, 1, 0);
      apply(1, 0, 1, 6, 0, 1, 0);
      apply(0, 0, 1, 6, 1, 1, 0);
      apply(1, 0, 0, 0, 0, 1, 0);
      apply(1, 0, 0, 0, 0, 1, 0);
      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         apply(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 4),
               ($urandom_range(0, 99) < 10), int'($urandom_range(0, 31)),
               ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 60),
               ($urandom_range(0, 99) < 80));
      end
      apply(1, 0, 0, 0, 0, 1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
